load_align_unit: RTL
====================

Name: load_align_unit

Overview:
Parametrised load-path successor to the register write-back data selector. Takes one load request at a time and issues one or two aligned bus reads; a misaligned access that crosses a word boundary needs two. It extracts the addressed byte, halfword, word or doubleword, sign- or zero-extends it to XLEN, and returns it on a valid/ready write-back port with a fault flag. It sits between the execute stage and the data-memory bus, in front of the register file write port.

Parameters:
XLEN, 32, datapath and bus width in bits; legal values are 32 and 64.
SPLIT_EN, 1, 1 = split misaligned cross-word loads into two beats; 0 = fault on any misaligned load.
RD_W, 5, destination register index width.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
ld_valid  input  1  load request valid
ld_ready  output  1  unit can accept a request; equals (state==IDLE)
ld_op  input  MEM_OP_WIDTH  load opcode: LB/LH/LW/LBU/LHU/LWU/LD
ld_addr  input  XLEN  byte address
ld_rd  input  RD_W  destination register
mem_req  output  1  bus read request
mem_gnt  input  1  request accepted this cycle
mem_addr  output  XLEN  aligned bus address; low log2(XLEN/8) bits are 0
mem_rvalid  input  1  read data valid
mem_rdata  input  XLEN  read data
mem_err  input  1  bus error; qualified by mem_rvalid
wb_valid  output  1  write-back valid
wb_ready  input  1  write-back accepted
wb_rd  output  RD_W  destination register
wb_data  output  XLEN  extended load result
wb_fault  output  1  load faulted; wb_data is 0 when set

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on rst.
- Reset values: state=IDLE, mem_req=0, mem_addr=0, wb_valid=0, wb_data=0, wb_rd=0, wb_fault=0, internal beat buffers=0.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- Decoding the request:
  - Size: 1/2/4/8 bytes from ld_op.
  - off = ld_addr mod (XLEN/8).
  - misaligned = (ld_addr mod size) != 0.
  - cross = off+size > XLEN/8.
- IDLE, on ld_valid&&ld_ready: latch op, addr and rd, then take the first matching branch:
  - Illegal op (LD or LWU with XLEN=32, or an undefined code) -> RESP with fault, no bus access.
  - Misaligned with SPLIT_EN=0 -> RESP with fault, no bus access.
  - Otherwise -> REQ0.
- REQ0: mem_req=1, mem_addr=aligned(addr). Hold both stable until mem_gnt, then go to WAIT0.
- WAIT0, on mem_rvalid:
  - Capture lo=mem_rdata.
  - If mem_err -> RESP with fault.
  - Else if cross -> REQ1.
  - Else -> RESP.
- REQ1: mem_req=1, mem_addr=aligned(addr)+XLEN/8, wrapping modulo 2^XLEN. Move to WAIT1 on mem_gnt.
- WAIT1, on mem_rvalid: capture hi=mem_rdata. If mem_err -> fault. Go to RESP.
- Extraction: shift {hi,lo} (2*XLEN bits; hi=0 when there is one beat) right by off*8 and take the size bits.
  - LB/LH/LW/LD: sign-extend to XLEN.
  - LBU/LHU/LWU: zero-extend.
  - LW at XLEN=32 passes through unchanged.
- RESP: wb_valid=1 with wb_data, wb_rd and wb_fault registered (computed on entry). Hold them until wb_ready, then go to IDLE. ld_ready=0 while in RESP; there is no bypass.
- Minimum aligned latency: request accepted at T, mem_req at T+1 with same-cycle gnt, rvalid at T+2, wb_valid at T+3.
- Split loads add 2 cycles minimum.
- mem_rvalid outside WAIT0/WAIT1 is ignored. mem_gnt outside REQ0/REQ1 is ignored.
- At most one outstanding bus read. mem_req is never asserted in WAIT states.
- rst mid-operation: return to IDLE the next cycle with all outputs at reset values. Late rvalid from an abandoned access is dropped.
- Fault after the first beat of a split load: the second beat is not issued.

Decomposition:
- Shared package cpu_defs: the MEM_OP_WIDTH and MEM_LB/LH/LW/LBU/LHU/LWU/LD codes, and the FSM state encoding localparams.
- One combinational sub-module, load_extract (inputs {hi,lo}, off, op; output XLEN result). It is reused by the store path's read-modify-write.
- The FSM and registers stay in load_align_unit.

Test Plan:
- XLEN=32, LB at addr 0x103, mem_rdata=0x80FF1234 -> one beat, mem_addr=0x100, wb_data=0xFFFFFF80, wb_fault=0, wb_valid at T+3 with gnt and rvalid immediate.
- LHU at 0x202, rdata=0xBEEF0000 -> wb_data=0x0000BEEF; LH at the same address -> 0xFFFFBEEF.
- SPLIT_EN=1, LW at 0x103, beat0 @0x100=0xAABBCCDD, beat1 @0x104=0x11223344 -> two requests, wb_data=0x223344AA.
- XLEN=64, LD at 0x7, rdata0=0x0123456789ABCDEF, rdata1=0xFEDCBA9876543210 -> wb_data=0xDCBA987654321001; LWU at 0x4 of rdata0 -> 0x0000000001234567.
- SPLIT_EN=0 with LW at 0x102, and separately XLEN=32 with LD -> no mem_req ever asserted, wb_fault=1, wb_data=0.
- Backpressure and faults:
  - Split load with beat0 mem_err=1 -> no second mem_req, wb_fault=1.
  - wb_ready held 0 for 5 cycles -> wb outputs stable and ld_ready=0 throughout.
  - rst during WAIT1 -> IDLE next cycle; a subsequent stray rvalid produces no wb_valid.

Source files
------------

// File: rtl/load_align_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_defs (package)
//  Description : Load opcode encodings, load-unit FSM state encoding and
//                small opcode decode helpers shared by the load/store paths.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    localparam int MEM_OP_WIDTH = 3;

    localparam logic [MEM_OP_WIDTH-1:0] MEM_LB  = 3'd0;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_LH  = 3'd1;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_LW  = 3'd2;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_LD  = 3'd3;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_LBU = 3'd4;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_LHU = 3'd5;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_LWU = 3'd6;

    localparam int STATE_WIDTH = 3;

    localparam logic [STATE_WIDTH-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_WIDTH-1:0] ST_REQ0  = 3'd1;
    localparam logic [STATE_WIDTH-1:0] ST_WAIT0 = 3'd2;
    localparam logic [STATE_WIDTH-1:0] ST_REQ1  = 3'd3;
    localparam logic [STATE_WIDTH-1:0] ST_WAIT1 = 3'd4;
    localparam logic [STATE_WIDTH-1:0] ST_RESP  = 3'd5;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE  = ST_IDLE,
        REQ0  = ST_REQ0,
        WAIT0 = ST_WAIT0,
        REQ1  = ST_REQ1,
        WAIT1 = ST_WAIT1,
        RESP  = ST_RESP
    } lau_state_e;

    // Access size in bytes; 0 marks an undefined opcode.
    function automatic logic [3:0] mem_op_size(input logic [MEM_OP_WIDTH-1:0] op);
        case (op)
            MEM_LB, MEM_LBU: mem_op_size = 4'd1;
            MEM_LH, MEM_LHU: mem_op_size = 4'd2;
            MEM_LW, MEM_LWU: mem_op_size = 4'd4;
            MEM_LD:          mem_op_size = 4'd8;
            default:         mem_op_size = 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align_unit_extract.sv
`default_nettype none
// ============================================================================
//  Module      : load_extract
//  Description : Selects the addressed byte/half/word/double out of a
//                two-beat window and sign- or zero-extends it to XLEN.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_extract
    import cpu_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0]         beats,
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [MEM_OP_WIDTH-1:0]   op,
    output logic [XLEN-1:0]           result
);

    logic [XLEN-1:0] w_shifted;

    // Bring the addressed byte down to bit 0 of the {hi,lo} window.
    assign w_shifted = XLEN'(beats >> {off, 3'b000});

    // Size selection and extension; LD only reaches here when XLEN is 64.
    always_comb begin
        result = '0;
        case (op)
            MEM_LB:  result = XLEN'($signed(w_shifted[7:0]));
            MEM_LH:  result = XLEN'($signed(w_shifted[15:0]));
            MEM_LW:  result = XLEN'($signed(w_shifted[31:0]));
            MEM_LD:  result = w_shifted;
            MEM_LBU: result = XLEN'(w_shifted[7:0]);
            MEM_LHU: result = XLEN'(w_shifted[15:0]);
            MEM_LWU: result = XLEN'(w_shifted[31:0]);
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_align_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_align_unit
//  Description : Load path between execute and the data bus. Issues one or
//                two aligned reads per load, extracts and extends the result
//                and hands it to write-back over a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align_unit
    import cpu_defs::*;
#(
    parameter int XLEN     = 32,
    parameter bit SPLIT_EN = 1'b1,
    parameter int RD_W     = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [MEM_OP_WIDTH-1:0] ld_op,
    input  logic [XLEN-1:0]         ld_addr,
    input  logic [RD_W-1:0]         ld_rd,
    output logic                    mem_req,
    input  logic                    mem_gnt,
    output logic [XLEN-1:0]         mem_addr,
    input  logic                    mem_rvalid,
    input  logic [XLEN-1:0]         mem_rdata,
    input  logic                    mem_err,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [RD_W-1:0]         wb_rd,
    output logic [XLEN-1:0]         wb_data,
    output logic                    wb_fault
);

    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);

    lau_state_e r_state;
    lau_state_e w_state_next;

    logic [MEM_OP_WIDTH-1:0] r_op;
    logic [XLEN-1:0]         r_addr;
    logic [RD_W-1:0]         r_rd;
    logic [XLEN-1:0]         r_lo;

    logic [3:0]      w_in_size;
    logic            w_in_illegal;
    logic            w_in_misaligned;
    logic [3:0]      w_r_size;
    logic            w_cross;
    logic [XLEN-1:0] w_base;
    logic            w_latch_req;
    logic            w_capture_lo;
    logic            w_enter_resp;
    logic            w_fault;
    logic [XLEN-1:0] w_ext_lo;
    logic [XLEN-1:0] w_ext_hi;
    logic [XLEN-1:0] w_ext;

    // Incoming request decode: undefined codes and 64-bit ops on a 32-bit bus are illegal.
    assign w_in_size       = mem_op_size(ld_op);
    assign w_in_illegal    = (w_in_size == 4'd0) ||
                             ((XLEN == 32) && ((ld_op == MEM_LD) || (ld_op == MEM_LWU)));
    assign w_in_misaligned = (ld_addr[3:0] & (w_in_size - 4'd1)) != 4'd0;

    // Latched request: does it spill into the next bus word?
    assign w_r_size = mem_op_size(r_op);
    assign w_cross  = (int'(r_addr[OFF_W-1:0]) + int'(w_r_size)) > BYTES;
    assign w_base   = {r_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};

    assign ld_ready = (r_state == IDLE);

    load_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .beats  ({w_ext_hi, w_ext_lo}),
        .off    (r_addr[OFF_W-1:0]),
        .op     (r_op),
        .result (w_ext)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, bus outputs and datapath strobes; beat data is fed to the
    // extractor straight from the bus on the cycle it arrives.
    always_comb begin
        w_state_next = r_state;
        w_latch_req  = 1'b0;
        w_capture_lo = 1'b0;
        w_enter_resp = 1'b0;
        w_fault      = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        w_ext_lo     = r_lo;
        w_ext_hi     = '0;
        case (r_state)
            IDLE: begin
                if (ld_valid) begin
                    w_latch_req = 1'b1;
                    if (w_in_illegal || (w_in_misaligned && !SPLIT_EN)) begin
                        w_state_next = RESP;
                        w_enter_resp = 1'b1;
                        w_fault      = 1'b1;
                    end else begin
                        w_state_next = REQ0;
                    end
                end
            end
            REQ0: begin
                mem_req  = 1'b1;
                mem_addr = w_base;
                if (mem_gnt) w_state_next = WAIT0;
            end
            WAIT0: begin
                w_ext_lo = mem_rdata;
                if (mem_rvalid) begin
                    w_capture_lo = 1'b1;
                    if (mem_err) begin
                        w_state_next = RESP;
                        w_enter_resp = 1'b1;
                        w_fault      = 1'b1;
                    end else if (w_cross) begin
                        w_state_next = REQ1;
                    end else begin
                        w_state_next = RESP;
                        w_enter_resp = 1'b1;
                    end
                end
            end
            REQ1: begin
                mem_req  = 1'b1;
                mem_addr = w_base + XLEN'(BYTES);
                if (mem_gnt) w_state_next = WAIT1;
            end
            WAIT1: begin
                w_ext_hi = mem_rdata;
                if (mem_rvalid) begin
                    w_state_next = RESP;
                    w_enter_resp = 1'b1;
                    w_fault      = mem_err;
                end
            end
            RESP: begin
                if (wb_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Request latch, first-beat buffer and registered write-back outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_addr   <= '0;
            r_rd     <= '0;
            r_lo     <= '0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_rd    <= '0;
            wb_fault <= 1'b0;
        end else begin
            if (w_latch_req) begin
                r_op   <= ld_op;
                r_addr <= ld_addr;
                r_rd   <= ld_rd;
            end
            if (w_capture_lo) r_lo <= mem_rdata;
            if (w_enter_resp) begin
                wb_valid <= 1'b1;
                wb_fault <= w_fault;
                wb_data  <= w_fault ? '0 : w_ext;
                wb_rd    <= w_latch_req ? ld_rd : r_rd;
            end else if ((r_state == RESP) && wb_ready) begin
                wb_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
